// File: rtl/id_ex_stage_pkg.sv
// Shared widths, opcodes and the ID/EX bundle for the decode stage.
// Opcode values follow the classic MIPS-I encoding.
package id_ex_stage_pkg;

    localparam int AWIDTH         = 32;
    localparam int OPCODE_WIDTH   = 6;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [OPCODE_WIDTH-1:0] RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] ADDI  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] ADDIU = 6'h09;
    localparam logic [OPCODE_WIDTH-1:0] SLTI  = 6'h0a;
    localparam logic [OPCODE_WIDTH-1:0] SLTIU = 6'h0b;
    localparam logic [OPCODE_WIDTH-1:0] ANDI  = 6'h0c;
    localparam logic [OPCODE_WIDTH-1:0] ORI   = 6'h0d;
    localparam logic [OPCODE_WIDTH-1:0] LOAD  = 6'h23;

    typedef struct packed {
        logic                      valid;
        logic [OPCODE_WIDTH-1:0]   opcode;
        logic [5:0]                funct;
        logic [AWIDTH-1:0]         imm;
        logic [AWIDTH-1:0]         rs_data;
        logic [AWIDTH-1:0]         rt_data;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      reg_write;
        logic                      mem_read;
        logic                      illegal;
    } id_ex_t;

    function automatic logic [AWIDTH-1:0] sext16(input logic [15:0] v);
        return {{(AWIDTH-16){v[15]}}, v};
    endfunction

    function automatic logic [AWIDTH-1:0] zext16(input logic [15:0] v);
        return {{(AWIDTH-16){1'b0}}, v};
    endfunction

endpackage

// File: rtl/id_ex_stage_decode.sv
// Combinational field decode: immediate extension, destination,
// write-back / load enables and illegal-opcode flag.
module id_decode
    import id_ex_stage_pkg::*;
(
    input  logic [31:0]               instr,
    output logic [AWIDTH-1:0]         imm,
    output logic [REG_ADDR_WIDTH-1:0] dest,
    output logic                      reg_write,
    output logic                      mem_read,
    output logic                      illegal
);

    logic [OPCODE_WIDTH-1:0] op;
    logic                    is_r;
    logic                    is_i;
    logic                    is_z;
    logic                    unused_rs;

    assign op        = instr[31:26];
    assign unused_rs = ^instr[25:21];

    always_comb begin
        is_r = (op == RTYPE);
        is_i = (op == LOAD)  || (op == ADDI) ||
               (op == ADDIU) || (op == SLTI) ||
               (op == SLTIU) || (op == ANDI) ||
               (op == ORI);
        is_z = (op == ANDI) || (op == ORI);
    end

    always_comb begin
        imm     = is_z ? zext16(instr[15:0])
                       : sext16(instr[15:0]);
        dest    = '0;
        illegal = 1'b0;
        unique case (1'b1)
            is_r:    dest = instr[15:11];
            is_i:    dest = instr[20:16];
            default: illegal = 1'b1;
        endcase
    end

    assign reg_write = (is_r | is_i) & (dest != '0);
    assign mem_read  = (op == LOAD);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with priority update and load-use bubble insertion.
// No forwarding happens here; operands pass straight through.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [31:0]               id_instr,
    input  logic [AWIDTH-1:0]         id_rs_data,
    input  logic [AWIDTH-1:0]         id_rt_data,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      hz_stall,
    output logic                      ex_valid,
    output logic [OPCODE_WIDTH-1:0]   ex_opcode,
    output logic [5:0]                ex_funct,
    output logic [AWIDTH-1:0]         ex_imm,
    output logic [AWIDTH-1:0]         ex_rs_data,
    output logic [AWIDTH-1:0]         ex_rt_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_dest,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_illegal
);

    id_ex_t                    ex_q;
    id_ex_t                    ex_d;
    logic [AWIDTH-1:0]         dec_imm;
    logic [REG_ADDR_WIDTH-1:0] dec_dest;
    logic                      dec_reg_write;
    logic                      dec_mem_read;
    logic                      dec_illegal;
    logic                      src_hit;

    id_decode u_decode (
        .instr     (id_instr),
        .imm       (dec_imm),
        .dest      (dec_dest),
        .reg_write (dec_reg_write),
        .mem_read  (dec_mem_read),
        .illegal   (dec_illegal)
    );

    always_comb begin
        ex_d = '0;
        if (id_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.opcode    = id_instr[31:26];
            ex_d.funct     = id_instr[5:0];
            ex_d.imm       = dec_imm;
            ex_d.rs_data   = id_rs_data;
            ex_d.rt_data   = id_rt_data;
            ex_d.dest      = dec_dest;
            ex_d.reg_write = dec_reg_write;
            ex_d.mem_read  = dec_mem_read;
            ex_d.illegal   = dec_illegal;
        end
    end

    // rt is only a source operand for R-type; I-type writes it.
    assign src_hit =
        (ex_q.dest == id_instr[25:21]) |
        ((id_instr[31:26] == RTYPE) &
         (ex_q.dest == id_instr[20:16]));

    assign hz_stall = ex_q.valid & ex_q.mem_read &
                      (ex_q.dest != '0) & id_valid & src_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q <= hz_stall ? '0 : ex_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct     = ex_q.funct;
    assign ex_imm       = ex_q.imm;
    assign ex_rs_data   = ex_q.rs_data;
    assign ex_rt_data   = ex_q.rt_data;
    assign ex_dest      = ex_q.dest;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a
// behavioural model of the ID/EX register and hazard rule.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        stall;
    logic        flush;
    logic        hz_stall;
    logic        ex_valid;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .stall        (stall),
        .flush        (flush),
        .hz_stall     (hz_stall),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_funct     (ex_funct),
        .ex_imm       (ex_imm),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_dest      (ex_dest),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_illegal   (ex_illegal)
    );

    typedef struct {
        bit        valid;
        bit [5:0]  op;
        bit [5:0]  funct;
        bit [31:0] imm;
        bit [31:0] rs;
        bit [31:0] rt;
        bit [4:0]  dest;
        bit        rw;
        bit        mr;
        bit        ill;
    } ex_m_t;

    ex_m_t model;
    ex_m_t bubble;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ex_m_t ref_load(input logic [31:0] ins,
                                       input logic [31:0] rs,
                                       input logic [31:0] rt);
        ex_m_t m;
        bit [5:0] op = ins[31:26];
        bit is_r = (op == 6'h00);
        bit is_i = op inside {6'h23, 6'h08, 6'h09, 6'h0a,
                              6'h0b, 6'h0c, 6'h0d};
        bit is_z = op inside {6'h0c, 6'h0d};
        int simm = int'($signed(ins[15:0]));
        m.valid = 1'b1;
        m.op    = op;
        m.funct = ins[5:0];
        m.imm   = is_z ? {16'h0, ins[15:0]} : 32'(simm);
        m.rs    = rs;
        m.rt    = rt;
        m.dest  = is_r ? ins[15:11] : (is_i ? ins[20:16] : 5'd0);
        m.rw    = (is_r || is_i) && (m.dest != 0);
        m.mr    = (op == 6'h23);
        m.ill   = !(is_r || is_i);
        return m;
    endfunction

    function automatic bit ref_hz(input ex_m_t m, input bit v,
                                  input logic [31:0] ins);
        bit uses;
        uses = (m.dest == ins[25:21]) ||
               ((ins[31:26] == 6'h00) && (m.dest == ins[20:16]));
        return m.valid && m.mr && (m.dest != 0) && v && uses;
    endfunction

    function automatic logic [31:0] r_ins(input int rs, input int rt,
                                          input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op,
                                          input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic check_model(input string pfx);
        check({pfx, "valid"}, ex_valid,     model.valid);
        check({pfx, "op"},    ex_opcode,    model.op);
        check({pfx, "funct"}, ex_funct,     model.funct);
        check({pfx, "imm"},   ex_imm,       model.imm);
        check({pfx, "rs"},    ex_rs_data,   model.rs);
        check({pfx, "rt"},    ex_rt_data,   model.rt);
        check({pfx, "dest"},  ex_dest,      model.dest);
        check({pfx, "rw"},    ex_reg_write, model.rw);
        check({pfx, "mr"},    ex_mem_read,  model.mr);
        check({pfx, "ill"},   ex_illegal,   model.ill);
    endtask

    // One cycle: drive at negedge, check, clock, update model.
    task automatic cyc(input bit r, input bit v,
                       input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input bit st, input bit fl, input bit chk,
                       output bit hz_o);
        bit hz_m;
        rst = r; id_valid = v; id_instr = ins;
        id_rs_data = rs; id_rt_data = rt;
        stall = st; flush = fl;
        #1;
        hz_m = ref_hz(model, v, ins);
        hz_o = hz_stall;
        if (chk) begin
            check("hz_stall", hz_stall, hz_m);
            check_model("ex_");
        end
        @(posedge clk);
        if (!r)       model = bubble;
        else if (fl)  model = bubble;
        else if (st)  model = model;
        else if (hz_m) model = bubble;
        else if (!v)  model = bubble;
        else          model = ref_load(ins, rs, rt);
        @(negedge clk);
    endtask

    bit       hz;
    bit [5:0] ops [10];

    initial begin
        bubble = '{default: '0};
        model  = bubble;
        ops = '{6'h00, 6'h23, 6'h08, 6'h09, 6'h0a,
                6'h0b, 6'h0c, 6'h0d, 6'h3f, 6'h00};
        @(negedge clk);

        // reset with arbitrary inputs, model not yet comparable
        cyc(0, 1, 32'hdead_beef, 32'h1234, 32'h5678, 1, 0, 0, hz);
        cyc(0, 1, 32'h8ca5_0000, 32'h1, 32'h2, 0, 1, 0, hz);
        cyc(1, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, hz);
        check("rst_valid", ex_valid, 0);
        check("rst_imm", ex_imm, 0);
        check("rst_hz", hz_stall, 0);

        cyc(1, 1, i_ins(ADDI, 1, 3, 16'hffff), 5, 9, 0, 0, 1, hz);
        check("addi_imm", ex_imm, 32'hffff_ffff);
        check("addi_dest", ex_dest, 3);
        check("addi_rw", ex_reg_write, 1);
        check("addi_rs", ex_rs_data, 5);

        cyc(1, 1, i_ins(ORI, 0, 4, 16'h8000), 0, 0, 0, 0, 1, hz);
        check("ori_imm", ex_imm, 32'h0000_8000);
        cyc(1, 1, r_ins(1, 2, 7, 32), 1, 2, 0, 0, 1, hz);
        check("r_dest7", ex_dest, 7);
        cyc(1, 1, r_ins(1, 2, 0, 32), 1, 2, 0, 0, 1, hz);
        check("r_rd0_rw", ex_reg_write, 0);

        // load-use: LOAD r5 then r1 = r5 + r2
        cyc(1, 1, i_ins(LOAD, 0, 5, 16'h4), 0, 0, 0, 0, 1, hz);
        cyc(1, 1, r_ins(5, 2, 1, 32), 11, 22, 0, 0, 1, hz);
        check("lu_hz_on", hz, 1);
        check("lu_bubble", ex_valid, 0);
        cyc(1, 1, r_ins(5, 2, 1, 32), 11, 22, 0, 0, 1, hz);
        check("lu_hz_off", hz, 0);
        check("lu_rtype_v", ex_valid, 1);
        check("lu_rtype_d", ex_dest, 1);
        check("lu_rtype_rs", ex_rs_data, 11);

        // load to r0 never hazards
        cyc(1, 1, i_ins(LOAD, 0, 0, 16'h4), 0, 0, 0, 0, 1, hz);
        cyc(1, 1, r_ins(0, 0, 1, 32), 0, 0, 0, 0, 1, hz);
        check("lu_r0_hz", hz, 0);

        // flush+stall wins as bubble
        cyc(1, 1, i_ins(ADDI, 1, 2, 16'h7), 1, 1, 1, 1, 1, hz);
        check("flst_valid", ex_valid, 0);

        // stall holds for several cycles
        cyc(1, 1, i_ins(ADDI, 1, 6, 16'h1234), 77, 0, 0, 0, 1, hz);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, i_ins(ORI, 2, 9, 16'h5555), 3, 4, 1, 0, 1, hz);
            check("stall_imm", ex_imm, 32'h1234);
            check("stall_rs", ex_rs_data, 77);
        end

        // hazard + stall: EX holds the load, hz stays up
        cyc(1, 1, i_ins(LOAD, 0, 8, 16'h0), 0, 0, 0, 0, 1, hz);
        cyc(1, 1, i_ins(ADDI, 8, 9, 16'h1), 0, 0, 1, 0, 1, hz);
        check("hzst_hz1", hz, 1);
        cyc(1, 1, i_ins(ADDI, 8, 9, 16'h1), 0, 0, 1, 0, 1, hz);
        check("hzst_hz2", hz, 1);
        check("hzst_mr", ex_mem_read, 1);

        // reset mid-hazard
        cyc(0, 1, i_ins(ADDI, 8, 9, 16'h1), 0, 0, 0, 0, 1, hz);
        check("rsthz_hz", hz_stall, 0);
        check("rsthz_v", ex_valid, 0);

        cyc(1, 1, {6'h3f, 26'h3ff_ffff}, 0, 0, 0, 0, 1, hz);
        check("ill_valid", ex_valid, 1);
        check("ill_flag", ex_illegal, 1);
        check("ill_rw", ex_reg_write, 0);
        check("ill_dest", ex_dest, 0);

        for (int n = 0; n < 800; n++) begin
            logic [31:0] ins;
            logic [5:0]  op;
            op  = ops[$urandom_range(9)];
            ins = $urandom;
            ins[31:26] = op;
            ins[25:21] = 5'($urandom_range(3));
            ins[20:16] = 5'($urandom_range(3));
            ins[15:11] = 5'($urandom_range(3));
            cyc($urandom_range(49) != 0,
                $urandom_range(7) != 0, ins, $urandom, $urandom,
                $urandom_range(7) == 0, $urandom_range(15) == 0,
                1, hz);
        end
        cyc(1, 0, 32'h0, 0, 0, 0, 0, 1, hz);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
